camera_frame_sched: RTL

CAMERA_FRAME_SCHED -- requirements
Module: camera_frame_sched

---
 rtl/camera_frame_sched_pkg.sv | 16 +
 rtl/camera_sched_done_det.sv | 30 +++
 rtl/camera_frame_sched.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/camera_frame_sched_pkg.sv
// Shared types for the camera frame scheduler: FSM state encoding and
// the uDMA ping/pong queue depth.
package camera_frame_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_SETTLE = 3'd2,
    S_RUN    = 3'd3,
    S_DRAIN  = 3'd4,
    S_CLEAR  = 3'd5
  } sched_state_e;

  localparam logic [1:0] MAX_OUTSTANDING = 2'd2;

endpackage

// File: rtl/camera_sched_done_det.sv
// Registers the uDMA channel status and flags a completed transfer on a
// falling pending bit (queued slot promoted) or a falling enable (last one).
module camera_sched_done_det (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic rx_en_i,
  input  logic rx_pending_i,
  output logic done_o
);

  logic r_en_q, r_en_d;
  logic r_pending_q, r_pending_d;

  always_comb begin
    r_en_d      = rx_en_i;
    r_pending_d = rx_pending_i;
    done_o      = (r_pending_q & ~rx_pending_i) | (r_en_q & ~rx_en_i);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_en_q      <= 1'b0;
      r_pending_q <= 1'b0;
    end else begin
      r_en_q      <= r_en_d;
      r_pending_q <= r_pending_d;
    end
  end

endmodule

// File: rtl/camera_frame_sched.sv
// Ping/pong frame capture scheduler: keeps up to two uDMA RX transfers
// queued, alternating buffers, and reports each completed frame.
module camera_frame_sched
  import camera_frame_sched_pkg::*;
#(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      cfg_start_i,
  input  logic                      cfg_stop_i,
  input  logic                      cfg_abort_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_buf0_addr_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_buf1_addr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_frame_size_i,
  input  logic [15:0]               cfg_num_frames_i,
  output logic [L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr_o,
  output logic [TRANS_SIZE-1:0]     cfg_rx_size_o,
  output logic                      cfg_rx_en_o,
  output logic                      cfg_rx_clr_o,
  input  logic                      cfg_rx_en_i,
  input  logic                      cfg_rx_pending_i,
  output logic                      cam_en_o,
  output logic                      busy_o,
  output logic                      evt_frame_o,
  output logic                      frame_buf_o,
  output logic [15:0]               frame_cnt_o
);

  sched_state_e state_q, state_d;
  logic [1:0]   outstanding_q, outstanding_d;
  logic         idx_q, idx_d;
  logic         oldest_q, oldest_d;
  logic [15:0]  issued_q, issued_d;
  logic [L2_AWIDTH_NOAL-1:0] addr_q, addr_d;
  logic [TRANS_SIZE-1:0]     size_q, size_d;
  logic         rx_en_q, rx_en_d;
  logic         rx_clr_q, rx_clr_d;
  logic         cam_en_q, cam_en_d;
  logic         busy_q, busy_d;
  logic         evt_q, evt_d;
  logic         frame_buf_q, frame_buf_d;
  logic [15:0]  frame_cnt_q, frame_cnt_d;

  logic done_s, abort_s, active_s, count_done_s, issue_s, more_s;

  camera_sched_done_det u_done_det (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .rx_en_i      (cfg_rx_en_i),
    .rx_pending_i (cfg_rx_pending_i),
    .done_o       (done_s)
  );

  always_comb begin
    state_d       = state_q;
    outstanding_d = outstanding_q;
    idx_d         = idx_q;
    oldest_d      = oldest_q;
    issued_d      = issued_q;
    addr_d        = addr_q;
    size_d        = size_q;
    rx_en_d       = 1'b0;
    evt_d         = 1'b0;
    frame_buf_d   = frame_buf_q;
    frame_cnt_d   = frame_cnt_q;

    issue_s  = (state_q == S_ISSUE);
    abort_s  = cfg_abort_i && (state_q != S_IDLE);
    active_s = (state_q == S_ISSUE) || (state_q == S_SETTLE) ||
               (state_q == S_RUN)   || (state_q == S_DRAIN);
    // Completions seen in IDLE/CLEAR or on the abort cycle belong to a dead run.
    count_done_s = done_s && active_s && !abort_s;
    more_s = (cfg_num_frames_i == 16'd0) || (issued_q < cfg_num_frames_i);

    case (state_q)
      S_IDLE: begin
        if (cfg_start_i) begin
          state_d       = S_ISSUE;
          frame_cnt_d   = 16'd0;
          idx_d         = 1'b0;
          oldest_d      = 1'b0;
          issued_d      = 16'd0;
          outstanding_d = 2'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        addr_d   = idx_q ? cfg_buf1_addr_i : cfg_buf0_addr_i;
        size_d   = cfg_frame_size_i;
        rx_en_d  = 1'b1;
        idx_d    = ~idx_q;
        issued_d = issued_q + 16'd1;
        state_d  = cfg_stop_i ? S_DRAIN : S_SETTLE;
      end
      S_SETTLE: state_d = cfg_stop_i ? S_DRAIN : S_RUN;
      S_RUN: begin
        if (cfg_stop_i || !more_s) begin
          state_d = S_DRAIN;
        end else if ((outstanding_q < MAX_OUTSTANDING) && !cfg_rx_pending_i) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: state_d = (outstanding_q == 2'd0) ? S_IDLE : S_DRAIN;
      S_CLEAR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (count_done_s) begin
      evt_d       = 1'b1;
      frame_buf_d = oldest_q;
      oldest_d    = ~oldest_q;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else begin
      evt_d = 1'b0;
    end

    if (abort_s || (state_q == S_CLEAR)) begin
      outstanding_d = 2'd0;
    end else if (issue_s && !count_done_s && (outstanding_q < MAX_OUTSTANDING)) begin
      outstanding_d = outstanding_q + 2'd1;
    end else if (count_done_s && !issue_s && (outstanding_q != 2'd0)) begin
      outstanding_d = outstanding_q - 2'd1;
    end else begin
      outstanding_d = outstanding_d;
    end

    if (abort_s) begin
      state_d = S_CLEAR;
    end else begin
      state_d = state_d;
    end

    cam_en_d = (state_d == S_ISSUE) || (state_d == S_SETTLE) || (state_d == S_RUN);
    busy_d   = (state_d != S_IDLE);
    rx_clr_d = (state_d == S_CLEAR);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= S_IDLE;
      outstanding_q <= 2'd0;
      idx_q         <= 1'b0;
      oldest_q      <= 1'b0;
      issued_q      <= 16'd0;
      addr_q        <= '0;
      size_q        <= '0;
      rx_en_q       <= 1'b0;
      rx_clr_q      <= 1'b0;
      cam_en_q      <= 1'b0;
      busy_q        <= 1'b0;
      evt_q         <= 1'b0;
      frame_buf_q   <= 1'b0;
      frame_cnt_q   <= 16'd0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      idx_q         <= idx_d;
      oldest_q      <= oldest_d;
      issued_q      <= issued_d;
      addr_q        <= addr_d;
      size_q        <= size_d;
      rx_en_q       <= rx_en_d;
      rx_clr_q      <= rx_clr_d;
      cam_en_q      <= cam_en_d;
      busy_q        <= busy_d;
      evt_q         <= evt_d;
      frame_buf_q   <= frame_buf_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign cfg_rx_startaddr_o = addr_q;
  assign cfg_rx_size_o      = size_q;
  assign cfg_rx_en_o        = rx_en_q;
  assign cfg_rx_clr_o       = rx_clr_q;
  assign cam_en_o           = cam_en_q;
  assign busy_o             = busy_q;
  assign evt_frame_o        = evt_q;
  assign frame_buf_o        = frame_buf_q;
  assign frame_cnt_o        = frame_cnt_q;

endmodule
